// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider FSM encoding and the divide-by-zero quotient.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } div_state_t;

    // Quotient reported on divide-by-zero: all ones in the low n bits.
    function automatic logic [63:0] div_zero_q(input int unsigned n);
        return (n >= 64) ? ~64'd0 : ((64'd1 << n) - 64'd1);
    endfunction

endpackage

// File: rtl/twos_negate_n.sv
// Conditional two's-complement negation: y = en ? -a : a.
// Latency: combinational.
// Backpressure: none.
// Ports: a (N-bit operand), en (negate when high), y (N-bit result).
module twos_negate_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic         en,
    output logic [N-1:0] y
);

    assign y = en ? (~a + N'(1)) : a;

endmodule

// File: rtl/seq_divider_n.sv
// Multi-cycle restoring divider, signed or unsigned, with div-by-zero and overflow flags.
// Latency: N+2 cycles from the accepting edge to done (2 cycles on divide-by-zero).
// Backpressure: start is only honoured in IDLE; a start while busy is dropped, not queued.
// Ports: clk, rst (async, active-high); start, signed_mode, dividend, divisor (captured on
//   the accepting edge); busy, done (one-cycle pulse); quotient, remainder, div_by_zero,
//   overflow (registered, held until the next done).
module seq_divider_n
    import arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0] DZ_Q    = N'(div_zero_q(N));
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      dvd_q, dvd_d;          // raw operands as captured
    logic [N-1:0]      dvs_q, dvs_d;
    logic              sgn_q, sgn_d;
    logic [N-1:0]      quo_q, quo_d;          // dividend magnitude shifting out, quotient shifting in
    logic [N-1:0]      rem_q, rem_d;          // partial remainder; always < |divisor| so N bits hold it
    logic [N-1:0]      mag_dvs_q, mag_dvs_d;
    logic              neg_q_q, neg_q_d;
    logic              neg_r_q, neg_r_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [N-1:0]      quotient_q, quotient_d;
    logic [N-1:0]      remainder_q, remainder_d;
    logic              div_by_zero_q, div_by_zero_d;
    logic              overflow_q, overflow_d;

    logic [N-1:0]      abs_dvd, abs_dvs, q_fixed, r_fixed;
    logic [N:0]        shifted, trial;

    twos_negate_n #(.N(N)) u_abs_dvd (.a(dvd_q), .en(sgn_q & dvd_q[N-1]), .y(abs_dvd));
    twos_negate_n #(.N(N)) u_abs_dvs (.a(dvs_q), .en(sgn_q & dvs_q[N-1]), .y(abs_dvs));
    twos_negate_n #(.N(N)) u_fix_quo (.a(quo_q), .en(neg_q_q),            .y(q_fixed));
    twos_negate_n #(.N(N)) u_fix_rem (.a(rem_q), .en(neg_r_q),            .y(r_fixed));

    // N+1-bit trial subtraction; bit N is the sign of (shifted - |divisor|).
    assign shifted = {rem_q, quo_q[N-1]};
    assign trial   = shifted - {1'b0, mag_dvs_q};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        sgn_d         = sgn_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        mag_dvs_d     = mag_dvs_q;
        neg_q_d       = neg_q_q;
        neg_r_d       = neg_r_q;
        dbz_d         = dbz_q;
        ovf_d         = ovf_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = signed_mode;
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                quo_d     = abs_dvd;
                mag_dvs_d = abs_dvs;
                neg_q_d   = sgn_q & (dvd_q[N-1] ^ dvs_q[N-1]);
                neg_r_d   = sgn_q & dvd_q[N-1];
                dbz_d     = (dvs_q == '0);
                // MIN / -1 needs no special datapath: |MIN| wraps back to MIN unnegated.
                ovf_d     = sgn_q & (dvd_q == MIN_NEG) & (dvs_q == '1);
                rem_d     = '0;
                cnt_d     = '0;
                state_d   = (dvs_q == '0) ? S_FIX : S_ITER;
            end
            S_ITER: begin
                rem_d = trial[N] ? shifted[N-1:0] : trial[N-1:0];
                quo_d = {quo_q[N-2:0], ~trial[N]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dbz_q) begin
                    quotient_d    = DZ_Q;
                    remainder_d   = dvd_q;
                    div_by_zero_d = 1'b1;
                    overflow_d    = 1'b0;
                end else begin
                    quotient_d    = q_fixed;
                    remainder_d   = r_fixed;
                    div_by_zero_d = 1'b0;
                    overflow_d    = ovf_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            sgn_q         <= 1'b0;
            quo_q         <= '0;
            rem_q         <= '0;
            mag_dvs_q     <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dvd_q         <= dvd_d;
            dvs_q         <= dvs_d;
            sgn_q         <= sgn_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            mag_dvs_q     <= mag_dvs_d;
            neg_q_q       <= neg_q_d;
            neg_r_q       <= neg_r_d;
            dbz_q         <= dbz_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider_n.sv
// Bench for seq_divider_n: directed N=8 cases plus random sweeps at N=5 and N=16.
// Latency: checks done timing against the accepting edge.
// Backpressure: exercises start-while-busy and start-on-done.
module tb_seq_divider_n;

    logic clk = 1'b0;
    logic rst;

    logic        start8, sm8, busy8, done8, dbz8, ovf8;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic        start5, sm5, busy5, done5, dbz5, ovf5;
    logic [4:0]  dvd5, dvs5, q5, r5;
    logic        start16, sm16, busy16, done16, dbz16, ovf16;
    logic [15:0] dvd16, dvs16, q16, r16;

    seq_divider_n #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .overflow(ovf8));

    seq_divider_n #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5),
        .dividend(dvd5), .divisor(dvs5), .busy(busy5), .done(done5),
        .quotient(q5), .remainder(r5), .div_by_zero(dbz5), .overflow(ovf5));

    seq_divider_n #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
        .quotient(q16), .remainder(r16), .div_by_zero(dbz16), .overflow(ovf16));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        busy;
        logic        done;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } obs_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model using the simulator's own integer divide (truncating, C-style %).
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input bit sgn);
        exp_t e;
        int   mask, ua, ub, sa, sb;
        mask  = (1 << w) - 1;
        ua    = int'(a) & mask;
        ub    = int'(b) & mask;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (ub == 0) begin
            e.q   = 16'(mask);
            e.r   = 16'(ua);
            e.dbz = 1'b1;
        end else if (sgn) begin
            sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
            sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
            if (sa == -(1 << (w - 1)) && sb == -1) begin
                e.q   = 16'(ua);
                e.r   = 16'd0;
                e.ovf = 1'b1;
            end else begin
                e.q = 16'((sa / sb) & mask);
                e.r = 16'((sa % sb) & mask);
            end
        end else begin
            e.q = 16'(ua / ub);
            e.r = 16'(ua % ub);
        end
        return e;
    endfunction

    task automatic drive(input int w, input bit st, input bit sg,
                         input logic [15:0] a, input logic [15:0] b);
        case (w)
            5:       begin start5  = st; sm5  = sg; dvd5  = a[4:0]; dvs5  = b[4:0]; end
            16:      begin start16 = st; sm16 = sg; dvd16 = a;      dvs16 = b;      end
            default: begin start8  = st; sm8  = sg; dvd8  = a[7:0]; dvs8  = b[7:0]; end
        endcase
    endtask

    function automatic obs_t sample(input int w);
        obs_t o;
        case (w)
            5:       begin o.busy = busy5;  o.done = done5;  o.q = 16'(q5);  o.r = 16'(r5);
                           o.dbz = dbz5;  o.ovf = ovf5;  end
            16:      begin o.busy = busy16; o.done = done16; o.q = q16;      o.r = r16;
                           o.dbz = dbz16; o.ovf = ovf16; end
            default: begin o.busy = busy8;  o.done = done8;  o.q = 16'(q8);  o.r = 16'(r8);
                           o.dbz = dbz8;  o.ovf = ovf8;  end
        endcase
        return o;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (so a following
    // call issues its start during the done cycle). poke_at >= 0 pulses a competing start.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input bit sgn, input int poke_at, input string tag);
        exp_t e;
        obs_t o;
        int   edges, busy_cnt, exp_lat;
        bit   got;
        sb_q.push_back(model(w, a, b, sgn));
        drive(w, 1'b1, sgn, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, ~sgn, ~a, ~b);
        edges    = 0;
        busy_cnt = 0;
        got      = 1'b0;
        o        = sample(w);
        while (edges <= 3 * w + 10) begin
            @(negedge clk);
            o = sample(w);
            if (o.done) begin
                got = 1'b1;
                break;
            end
            if (o.busy) busy_cnt++;
            if (edges == poke_at)          drive(w, 1'b1, 1'b1, 16'd55, 16'd3);
            else if (edges == poke_at + 1) drive(w, 1'b0, 1'b0, 16'd0, 16'd0);
            @(posedge clk);
            edges++;
        end
        if (!got) @(negedge clk);
        e       = sb_q.pop_front();
        exp_lat = e.dbz ? 2 : w + 2;
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"},   32'(edges), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, " busy_at_done"}, 32'(o.busy), 32'd0);
        check({tag, " quotient"},  32'(o.q), 32'(e.q));
        check({tag, " remainder"}, 32'(o.r), 32'(e.r));
        check({tag, " div_by_zero"}, 32'(o.dbz), 32'(e.dbz));
        check({tag, " overflow"},  32'(o.ovf), 32'(e.ovf));
    endtask

    initial begin
        logic [15:0] ra, rb, mask;
        bit          rs;
        int          sel;

        rst = 1'b1;
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(5, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
        #12;
        check("reset busy",      32'(busy8), 32'd0);
        check("reset done",      32'(done8), 32'd0);
        check("reset quotient",  32'(q8),    32'd0);
        check("reset remainder", 32'(r8),    32'd0);
        check("reset dbz",       32'(dbz8),  32'd0);
        check("reset ovf",       32'(ovf8),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(8, 16'd100, 16'd7,   1'b0, -1, "u100/7");
        run_op(8, 16'h9C,  16'h07,  1'b1, -1, "s-100/7");
        run_op(8, 16'd100, 16'hF9,  1'b1, -1, "s100/-7");
        run_op(8, 16'd37,  16'd0,   1'b0, -1, "u37/0");
        run_op(8, 16'd37,  16'd0,   1'b1, -1, "s37/0");
        run_op(8, 16'h80,  16'hFF,  1'b0, -1, "u80/FF");
        run_op(8, 16'd100, 16'd7,   1'b0,  4, "ignored_start");
        run_op(8, 16'd200, 16'd13,  1'b0, -1, "back_to_back");
        run_op(8, 16'h80,  16'hFF,  1'b1, -1, "s80/FF_ovf");

        // Abort mid-ITER: outputs must clear asynchronously, before any clock edge.
        drive(8, 1'b1, 1'b0, 16'd100, 16'd7);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_rst busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst busy",      32'(busy8), 32'd0);
        check("async_rst done",      32'(done8), 32'd0);
        check("async_rst quotient",  32'(q8),    32'd0);
        check("async_rst remainder", 32'(r8),    32'd0);
        check("async_rst dbz",       32'(dbz8),  32'd0);
        check("async_rst ovf",       32'(ovf8),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(8, 16'd250, 16'd3, 1'b0, -1, "after_rst");

        for (int w = 5; w <= 16; w += 11) begin
            mask = 16'((32'd1 << w) - 32'd1);
            for (int i = 0; i < 40; i++) begin
                ra  = 16'($urandom) & mask;
                rb  = 16'($urandom) & mask;
                rs  = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 7);
                if (sel == 0) begin
                    rb = 16'd0;
                end else if (sel == 1) begin
                    ra = 16'(32'd1 << (w - 1));
                    rb = mask;
                    rs = 1'b1;
                end
                run_op(w, ra, rb, rs, -1, $sformatf("sweep%0d_%0d", w, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
